// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one FIFO write port among NREQ producers.
//   A producer is granted for a burst of up to MAX_BURST beats; one idle
//   arbitration cycle separates consecutive grants.
//
// Handshake: a beat transfers on a rising clk edge when req_valid[i] and
//   req_ready[i] are both high. A producer holds req_valid/req_data/req_last
//   stable until the beat is accepted. req_ready is only ever high for the
//   current owner, and only when the FIFO is not full.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  per-requester beat valid
//   req_data   requester i data in [i*DW +: DW]
//   req_last   final beat of a requester's burst
//   req_ready  per-requester beat accept
//   fifo_full  FIFO full flag
//   fifo_write FIFO write strobe (one per accepted beat)
//   fifo_din   FIFO write data
//   grant_id   index of the current or most recent owner
//   busy       high while a grant is active (state BURST)
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  localparam int GW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  output logic               fifo_write,
  output logic [DW-1:0]      fifo_din,
  output logic [GW-1:0]      grant_id,
  output logic               busy
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t         state, state_d;
  logic [GW-1:0]  owner, owner_d;
  logic [GW-1:0]  last_grant, last_grant_d;
  logic [3:0]     beat_cnt, beat_cnt_d;

  logic           sel_found;
  logic [GW-1:0]  sel_idx;
  logic [GW-1:0]  cand;
  logic           beat;
  logic           burst_end;

  function automatic logic [GW-1:0] wrap_idx(input int i);
    return GW'(i % NREQ);
  endfunction

  // Round-robin search starting just after the previous owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = wrap_idx(int'(last_grant) + k);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign beat      = (state == BURST) && req_valid[owner] && !fifo_full;
  // req_last and the beat-count limit landing on the same beat give one end.
  assign burst_end = req_last[owner] || ((beat_cnt + 4'd1) == 4'(MAX_BURST));

  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_grant_d = last_grant;
    beat_cnt_d   = beat_cnt;
    req_ready    = '0;
    fifo_write   = 1'b0;
    fifo_din     = '0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          owner_d    = sel_idx;
          beat_cnt_d = 4'd0;
          state_d    = BURST;
        end
      end
      BURST: begin
        req_ready[owner] = !fifo_full;
        fifo_write       = beat;
        fifo_din         = req_data[int'(owner)*DW +: DW];
        // A full FIFO holds the grant: no beat, no count, no release.
        if (!fifo_full) begin
          if (!req_valid[owner] || burst_end) begin
            last_grant_d = owner;
            beat_cnt_d   = 4'd0;
            state_d      = IDLE;
          end else begin
            beat_cnt_d = beat_cnt + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= GW'(NREQ - 1);
      beat_cnt   <= 4'd0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_grant <= last_grant_d;
      beat_cnt   <= beat_cnt_d;
    end
  end

  // owner is only updated on a new grant, so it doubles as grant_id.
  assign grant_id = owner;
  assign busy     = (state == BURST);

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one 8-bit-wide FIFO write interface among NREQ producers.
- Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to MAX_BURST beats and drives the FIFO write strobe and data.
- Sits directly in front of the FIFO's write/din/full pins. The read side is untouched.

Parameters:
- NREQ, 4, number of requesters (2..8); GW = clog2(NREQ).
- DW, 8, data width per beat.
- MAX_BURST, 4, maximum beats per grant (1..15).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  per-requester beat valid
- req_data  input  NREQ*DW  requester i data in bits [i*DW +: DW]
- req_last  input  NREQ  marks final beat of a requester's burst
- req_ready  output  NREQ  per-requester beat accept
- fifo_full  input  1  FIFO full flag
- fifo_write  output  1  FIFO write strobe
- fifo_din  output  DW  FIFO write data
- grant_id  output  GW  index of current or last owner
- busy  output  1  high while in BURST

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values (applied immediately, asynchronously): state=IDLE, owner=0, last_grant=NREQ-1, beat_cnt=0, busy=0, grant_id=0, req_ready=0, fifo_write=0, fifo_din=0.
  - last_grant=NREQ-1 gives requester 0 top priority after reset.
- FSM states: IDLE, BURST.
- IDLE:
  - req_ready=0, fifo_write=0.
  - If any req_valid: select the first asserted index searching last_grant+1, last_grant+2, ... modulo NREQ.
  - Register owner=grant_id=selected, beat_cnt=0, go to BURST.
  - Otherwise stay in IDLE.
  - This costs one arbitration bubble cycle per grant.
- BURST combinational outputs:
  - req_ready[owner] = !fifo_full; all other req_ready bits are 0.
  - beat = req_valid[owner] & !fifo_full.
  - fifo_write = beat; fifo_din = req_data[owner] while in BURST, else 0.
- BURST sequential, on each beat:
  - beat_cnt increments.
  - Burst ends if req_last[owner]=1 or beat_cnt+1 == MAX_BURST.
- BURST release without a beat:
  - If req_valid[owner]=0 while fifo_full=0 (owner idle), release without a beat.
  - If fifo_full=1, hold the grant regardless of valid. No beat and no count.
- On burst end or release:
  - last_grant=owner, beat_cnt=0, state=IDLE.
  - grant_id keeps its value until the next grant.
- busy = (state==BURST).
- Exactly one fifo_write per accepted beat. Never write while fifo_full=1. No beat is lost or duplicated.
- Requesters that are not granted see ready=0 and must hold valid/data stable (standard valid/ready rule).
- Simultaneous req_last and MAX_BURST on the same beat: a single end of burst.
- A requester asserting valid while in IDLE with no competition: granted next cycle, first write the cycle after that.
- Reset mid-burst: the grant is dropped immediately and the in-flight beat is not written. Arbitration restarts from requester 0.
- beat_cnt width: 4 bits; never exceeds MAX_BURST-1.

Test Plan:
1. Reset then req_valid=4'b0001 with data 0x11,0x22,0x33 and last on the third beat -> grant_id=0 one cycle after valid; fifo_write on 3 consecutive cycles with din 0x11,0x22,0x33; busy falls; req_ready[1..3]=0 throughout.
2. All four requesters hold valid and never assert last -> grants cycle 0,1,2,3,0. Each burst is exactly 4 writes with a 1-cycle IDLE gap between bursts, giving 20 writes per 5 grants plus 5 bubble cycles.
3. Requester 2 bursting, fifo_full asserted for 3 cycles after its 2nd beat -> req_ready[2]=0 and fifo_write=0 for those 3 cycles; grant held; beats 3–4 written after full drops; total 4 writes, no duplicates.
4. Requester 1 granted, drops valid after 1 beat with fifo_full=0 -> release to IDLE. Next winner is the lowest index after 1 with valid (e.g. 3 when req_valid=4'b1001).
5. rst pulsed asynchronously mid-cycle during a burst by requester 3 -> req_ready and fifo_write go 0 immediately. After release, with requesters 0 and 3 both valid, requester 0 is granted first.
6. Requester 0 asserts last and the count reaches MAX_BURST on the same beat (4th beat) -> single burst end, exactly 4 writes, then requester 1 wins the next arbitration.
